// File: rtl/qep_filter_pkg.sv
// qep_filter_pkg -- shared constants for the QEP input filter.
//   QUAL_LEN_DEF / GLITCH_W_DEF : parameter defaults used by top and channel
//   qcnt_w()                    : width of a qualification counter that must
//                                 be able to hold the value QUAL_LEN
//   CH_A / CH_B / CH_I          : channel bit positions on qep_in / qep_out
package qep_filter_pkg;

  localparam int QUAL_LEN_DEF = 4;
  localparam int GLITCH_W_DEF = 8;

  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_I = 2;

  function automatic int qcnt_w(input int qual_len);
    return $clog2(qual_len + 1);
  endfunction

endpackage

// File: rtl/qep_filter_chan.sv
// qep_filter_chan -- one filtered encoder channel.
//   clk, reset_n    : clock, async active-low reset
//   enable_i        : filter run enable (qualification count held at 0 when low)
//   strobe_i        : shared sample strobe from the top-level prescaler
//   glitch_clr_i    : synchronous clear of the glitch counter
//   qep_i           : raw asynchronous pin
//   out_o           : qualified level
//   rise_o / fall_o : one-cycle pulses coincident with out_o changing
//   glitch_cnt_o    : saturating count of rejected glitches
// Glitch counter is built only when QEP_FILTER_GLITCH_CNT_EN is defined;
// otherwise glitch_cnt_o is tied to 0 and no counter flops exist.
module qep_filter_chan
  import qep_filter_pkg::*;
#(
  parameter int QUAL_LEN = QUAL_LEN_DEF,
  parameter int GLITCH_W = GLITCH_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable_i,
  input  logic                strobe_i,
  input  logic                glitch_clr_i,
  input  logic                qep_i,
  output logic                out_o,
  output logic                rise_o,
  output logic                fall_o,
  output logic [GLITCH_W-1:0] glitch_cnt_o
);

  localparam int QW = qcnt_w(QUAL_LEN);

  logic          sync1_q, safe_q;
  logic          out_q, out_d;
  logic          rise_q, rise_d, fall_q, fall_d;
  logic [QW-1:0] qcnt_q, qcnt_d, qinc;
  logic          glitch;

  always_comb begin
    qcnt_d = qcnt_q;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    glitch = 1'b0;
    qinc   = qcnt_q + QW'(1);
    if (!enable_i) begin
      qcnt_d = '0;
    end else if (strobe_i) begin
      if (safe_q != out_q) begin
        // Toggle on the sample that would bring the count to QUAL_LEN.
        if (qinc == QW'(QUAL_LEN)) begin
          out_d  = ~out_q;
          qcnt_d = '0;
          rise_d = ~out_q;
          fall_d = out_q;
        end else begin
          qcnt_d = qinc;
        end
      end else begin
        // A run that ended before qualifying is a rejected glitch.
        glitch = (qcnt_q != '0);
        qcnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      safe_q  <= 1'b0;
      qcnt_q  <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= qep_i;
      safe_q  <= sync1_q;
      qcnt_q  <= qcnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign out_o  = out_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

`ifdef QEP_FILTER_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] gcnt_q, gcnt_d;

  // Clear wins over a same-cycle increment; saturate at all-ones.
  always_comb begin
    gcnt_d = gcnt_q;
    if (glitch_clr_i)
      gcnt_d = '0;
    else if (glitch && (gcnt_q != '1))
      gcnt_d = gcnt_q + GLITCH_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) gcnt_q <= '0;
    else          gcnt_q <= gcnt_d;
  end

  assign glitch_cnt_o = gcnt_q;
`else
  logic unused_glitch;
  assign unused_glitch = glitch ^ glitch_clr_i;
  assign glitch_cnt_o  = '0;
`endif

endmodule

// File: rtl/qep_input_filter.sv
// qep_input_filter -- digital noise filter for quadrature encoder pins.
//   clk, reset_n : clock, async active-low reset
//   enable       : filter run enable
//   prescale     : sample strobe fires every prescale+1 clocks
//   qep_in       : raw encoder pins (NUM_CH)
//   qep_out      : qualified levels
//   qep_rise     : one-cycle pulse on qep_out 0->1
//   qep_fall     : one-cycle pulse on qep_out 1->0
//   glitch_clr   : synchronous clear of all glitch counters
//   glitch_cnt   : per-channel glitch counts, channel 0 in the LSBs
// Optional: define QEP_FILTER_GLITCH_CNT_EN to build the glitch counters;
// without it glitch_cnt reads 0 and glitch_clr is ignored.
module qep_input_filter
  import qep_filter_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int QUAL_LEN   = QUAL_LEN_DEF,
  parameter int PRESCALE_W = 8,
  parameter int GLITCH_W   = GLITCH_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [PRESCALE_W-1:0]        prescale,
  input  logic [NUM_CH-1:0]            qep_in,
  output logic [NUM_CH-1:0]            qep_out,
  output logic [NUM_CH-1:0]            qep_rise,
  output logic [NUM_CH-1:0]            qep_fall,
  input  logic                         glitch_clr,
  output logic [NUM_CH*GLITCH_W-1:0]   glitch_cnt
);

  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic                  strobe;

  // >= rather than == so a prescale lowered below the running count
  // strobes on the next clock instead of waiting for a wrap.
  assign strobe = enable && (pcnt_q >= prescale);

  always_comb begin
    pcnt_d = pcnt_q + PRESCALE_W'(1);
    if (!enable || strobe) pcnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pcnt_q <= '0;
    else          pcnt_q <= pcnt_d;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    qep_filter_chan #(
      .QUAL_LEN (QUAL_LEN),
      .GLITCH_W (GLITCH_W)
    ) u_chan (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable_i     (enable),
      .strobe_i     (strobe),
      .glitch_clr_i (glitch_clr),
      .qep_i        (qep_in[c]),
      .out_o        (qep_out[c]),
      .rise_o       (qep_rise[c]),
      .fall_o       (qep_fall[c]),
      .glitch_cnt_o (glitch_cnt[c*GLITCH_W +: GLITCH_W])
    );
  end

endmodule

// File: tb/tb_qep_input_filter.sv
// tb_qep_input_filter -- directed scenarios followed by random stimulus,
// every cycle compared against a behavioural model of the filter rules.
module tb_qep_input_filter;

  localparam int NCH  = 3;
  localparam int QL   = 4;
  localparam int PW   = 8;
  localparam int GW   = 4;
  localparam int GMAX = (1 << GW) - 1;
`ifdef QEP_FILTER_GLITCH_CNT_EN
  localparam bit GL_EN = 1'b1;
`else
  localparam bit GL_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic [PW-1:0]     prescale;
  logic [NCH-1:0]    qep_in;
  logic [NCH-1:0]    qep_out, qep_rise, qep_fall;
  logic              glitch_clr;
  logic [NCH*GW-1:0] glitch_cnt;

  int checks   = 0;
  int failures = 0;

  qep_input_filter #(
    .NUM_CH (NCH), .QUAL_LEN (QL), .PRESCALE_W (PW), .GLITCH_W (GW)
  ) dut (
    .clk (clk), .reset_n (reset_n), .enable (enable), .prescale (prescale),
    .qep_in (qep_in), .qep_out (qep_out), .qep_rise (qep_rise),
    .qep_fall (qep_fall), .glitch_clr (glitch_clr), .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // pin history (two-stage delay), clocks since last strobe, length of the
  // current run of samples disagreeing with the output, output, pulses, glitches
  bit m_hist [NCH][2];
  int m_since;
  int m_run  [NCH];
  bit m_out  [NCH];
  bit m_rise [NCH];
  bit m_fall [NCH];
  int m_gl   [NCH];

  task automatic model_reset();
    m_since = 0;
    for (int c = 0; c < NCH; c++) begin
      m_hist[c][0] = 0; m_hist[c][1] = 0;
      m_run[c] = 0; m_out[c] = 0; m_rise[c] = 0; m_fall[c] = 0; m_gl[c] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit stb;
    stb = enable && (m_since >= int'(prescale));
    m_since = (!enable || stb) ? 0 : m_since + 1;
    for (int c = 0; c < NCH; c++) begin
      m_rise[c] = 0; m_fall[c] = 0;
      if (stb) begin
        if (m_hist[c][1] != m_out[c]) begin
          m_run[c]++;
          if (m_run[c] == QL) begin
            m_out[c] = !m_out[c];
            m_run[c] = 0;
            if (m_out[c]) m_rise[c] = 1; else m_fall[c] = 1;
          end
        end else begin
          if (m_run[c] > 0 && GL_EN && m_gl[c] < GMAX) m_gl[c]++;
          m_run[c] = 0;
        end
      end else if (!enable) begin
        m_run[c] = 0;
      end
      if (glitch_clr && GL_EN) m_gl[c] = 0;
      m_hist[c][1] = m_hist[c][0];
      m_hist[c][0] = qep_in[c];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [NCH-1:0]    eo, er, ef;
    logic [NCH*GW-1:0] eg;
    for (int c = 0; c < NCH; c++) begin
      eo[c] = m_out[c]; er[c] = m_rise[c]; ef[c] = m_fall[c];
      eg[c*GW +: GW] = GW'(m_gl[c]);
    end
    chk("model_out",    32'(qep_out),    32'(eo));
    chk("model_rise",   32'(qep_rise),   32'(er));
    chk("model_fall",   32'(qep_fall),   32'(ef));
    chk("model_glitch", 32'(glitch_cnt), 32'(eg));
  endtask

  // Inputs are applied 1 time unit after an edge; sample likewise.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  function automatic logic [GW-1:0] gl(input int c);
    return glitch_cnt[c*GW +: GW];
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_out"},    32'(qep_out),    32'd0);
    chk({tag, "_rise"},   32'(qep_rise),   32'd0);
    chk({tag, "_fall"},   32'(qep_fall),   32'd0);
    chk({tag, "_glitch"}, 32'(glitch_cnt), 32'd0);
  endtask

  int nrise, nfall;

  initial begin
    reset_n = 1'b0; enable = 1'b0; prescale = '0; qep_in = '0; glitch_clr = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset");
    reset_n = 1'b1;
    enable  = 1'b1;

    // Short pulse on channel 1: three qualifying samples then back low.
    repeat (3) tick();
    qep_in[1] = 1'b1;
    repeat (3) tick();
    qep_in[1] = 1'b0;
    repeat (6) tick();
    chk("glitch_ch1_out", 32'(qep_out[1]), 32'd0);
    chk("glitch_ch1_cnt", 32'(gl(1)), GL_EN ? 32'd1 : 32'd0);

    // 20 one-clock glitches on channel 0 saturate a 4-bit counter.
    for (int g = 0; g < 20; g++) begin
      qep_in[0] = 1'b1; tick();
      qep_in[0] = 1'b0; tick(); tick();
    end
    repeat (3) tick();
    chk("glitch_sat", 32'(gl(0)), GL_EN ? 32'(GMAX) : 32'd0);
    chk("glitch_sat_out", 32'(qep_out[0]), 32'd0);

    // Clear in the same cycle the next glitch is counted.
    qep_in[0] = 1'b1; tick();
    qep_in[0] = 1'b0; tick(); tick();
    glitch_clr = 1'b1; tick();
    glitch_clr = 1'b0;
    chk("glitch_clr_prio", 32'(gl(0)), 32'd0);
    tick();
    chk("glitch_clr_hold", 32'(gl(0)), 32'd0);

    // Clean step on channel 0: output changes on the 6th edge counting the
    // edge that first captures the new level.
    repeat (3) tick();
    qep_in[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k < 6) chk("step_out_wait", 32'(qep_out[0]), 32'd0);
      if (k == 6) begin
        chk("step_out_edge6", 32'(qep_out[0]), 32'd1);
        chk("step_rise_edge6", 32'(qep_rise[0]), 32'd1);
      end
      if (k == 7) chk("step_rise_1cyc", 32'(qep_rise[0]), 32'd0);
    end

    // Disabled during a step: output holds, then QUAL_LEN strobes after enable.
    enable = 1'b0;
    qep_in[0] = 1'b0;
    repeat (10) tick();
    chk("dis_hold_out", 32'(qep_out[0]), 32'd1);
    chk("dis_no_fall", 32'(qep_fall[0]), 32'd0);
    enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k < 4) chk("en_wait", 32'(qep_out[0]), 32'd1);
      else begin
        chk("en_out_4strobes", 32'(qep_out[0]), 32'd0);
        chk("en_fall_4strobes", 32'(qep_fall[0]), 32'd1);
      end
    end

    // prescale=9: 40-clock high pulse on channel 2 qualifies once and
    // falls once.
    prescale = 8'd9;
    qep_in[2] = 1'b1;
    nrise = 0; nfall = 0;
    for (int k = 0; k < 120; k++) begin
      if (k == 40) qep_in[2] = 1'b0;
      tick();
      nrise += int'(qep_rise[2]);
      nfall += int'(qep_fall[2]);
      chk("no_rise_and_fall", 32'(qep_rise & qep_fall), 32'd0);
    end
    chk("ps9_rise_count", 32'(nrise), 32'd1);
    chk("ps9_fall_count", 32'(nfall), 32'd1);
    chk("ps9_out_final", 32'(qep_out[2]), 32'd0);

    // Reset after two of four qualifying samples.
    prescale = 8'd0;
    repeat (2) tick();
    qep_in[1] = 1'b1;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    check_all_zero("midqual_reset");
    model_reset();
    #2;
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k < 6) chk("post_reset_wait", 32'(qep_out[1]), 32'd0);
      else       chk("post_reset_qual", 32'(qep_out[1]), 32'd1);
    end

    // Random runs, enable drops, prescale changes and occasional clears.
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 3) == 0) qep_in[c] = ~qep_in[c];
      if ($urandom_range(0, 49) == 0) prescale = PW'($urandom_range(0, 3));
      enable     = ($urandom_range(0, 19) != 0);
      glitch_clr = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
